bcd_serial_converter: RTL
=========================

Name: bcd_serial_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the BCD-to-LCD-character pattern stage. Each 4-bit digit of its output feeds one pattern converter, which yields the character codes written by the LCD controller. A start/busy/done handshake lets the LCD sequencer request a conversion and know when the digits are stable.

Parameters:
BIN_WIDTH, 16, width of the unsigned binary input; legal range 4..32.
DIGITS, 5, number of BCD digits produced; bcdOut width is 4*DIGITS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  conversion request, sampled only in IDLE.
binIn  input  BIN_WIDTH  unsigned binary value, captured on the accepted start cycle.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when bcdOut and overflow are updated.
bcdOut  output  4*DIGITS  result digits; the least significant digit is in bits [3:0]; each nibble is 0..9.
overflow  output  1  set when the value exceeded 10^DIGITS-1; valid with done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, bcdOut=0, overflow=0, and all internal shift, scratch and counter registers cleared. A reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1, latch binIn into the shift register, clear the BCD scratch, bit counter=0 and overflow scratch=0.
  - Set busy=1 and go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every scratch nibble >=5 gets +3 (combinational, all nibbles in parallel).
  - Then shift {scratch, binary} left by 1.
  - The bit shifted out of the top scratch nibble ORs into the overflow scratch.
  - Counter increments. After the BIN_WIDTH-th shift, go to FINISH.
- FINISH (one cycle): bcdOut<=scratch, overflow<=overflow scratch, done=1, busy=0, go to IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+BIN_WIDTH+1. For the default this is 18 cycles from accepted start to done, inclusive.
- done is high for exactly one cycle, and only in the FINISH-to-IDLE transition.
- busy is high from the cycle after the accepted start through the last SHIFT cycle.
- start while busy=1 or in FINISH is ignored, not queued. Changes to binIn during conversion have no effect.
- Back-to-back: start asserted in the cycle done is high is accepted (the block is already in IDLE), so a new conversion begins immediately.
- bcdOut and overflow hold their last values between conversions and change only on the FINISH cycle.
- Truncation: when overflow=1, bcdOut is value mod 10^DIGITS. Lower digits are exact because no correction propagates downward.
- Arithmetic:
  - Add-3 is performed on 4-bit nibbles and never carries between nibbles.
  - The scratch register is exactly 4*DIGITS bits.
  - The counter is wide enough for BIN_WIDTH; wrap-around cannot occur.

Test Plan:
- binIn=0, start pulse → done after 18 cycles, bcdOut=20'h00000, overflow=0, busy high for 16 cycles.
- binIn=16'd65535 → bcdOut=20'h65535, overflow=0. binIn=16'd1234 → bcdOut=20'h01234. Every nibble checked to be <=9.
- Pulse start with binIn=42, then re-pulse start with binIn=999 at cycle 5 → request ignored; single done, bcdOut=20'h00042.
- Assert reset at cycle 8 of a conversion of 9999 → immediate busy=0, bcdOut=0, no done. A new start then gives 20'h09999 with full latency.
- Start held high continuously with binIn=7 then 8 → consecutive conversions, done pulses spaced 18 cycles apart, results 20'h00007 then 20'h00008.
- DIGITS=4, binIn=16'd65535 → overflow=1, bcdOut=16'h5535. With binIn=9999 → overflow=0, bcdOut=16'h9999.

Source files
------------

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start/busy/done handshake brackets each conversion; results hold between conversions.
module bcd_serial_converter #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   binIn,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcdOut,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t             state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d, scr_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_scr_q, ovf_scr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    // Per-nibble correction; the 4-bit sum never carries into the next digit.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        scr_adj   = add3_nibbles(scr_q);
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_scr_d = ovf_scr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = binIn;
                    scr_d     = '0;
                    cnt_d     = '0;
                    ovf_scr_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = {scr_adj[BCD_W-2:0], bin_q, 1'b0};
                ovf_scr_d      = ovf_scr_q | scr_adj[BCD_W-1];
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scr_q;
                ovf_d   = ovf_scr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            ovf_scr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            ovf_scr_q <= ovf_scr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcdOut   = bcd_q;
    assign overflow = ovf_q;

endmodule
